writeback: RTL and testbench

Writeback stage of the five-stage Y86-64 pipeline: holds the W pipeline register and produces the register-file write ports (dstE/valE, dstM/valM) that the decode stage both writes into its register file and uses as its lowest-priority forwarding sources. It also tracks processor status and counts retired instructions. On the first non-AOK status to reach W, it latches that status, freezes, and suppresses further writes.

---
 rtl/writeback.sv | 114 +++++++++++
 tb/tb_writeback.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, gated register-file write ports, status and counters.
// Outputs are registered one cycle after M-stage capture; no handshake, stall/bubble hold or clear W every edge.
module writeback #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [63:0]      M_valE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [63:0]      m_valM_i,
  output logic [3:0]       W_icode_o,
  output logic [3:0]       W_dstE_o,
  output logic [63:0]      W_valE_o,
  output logic [3:0]       W_dstM_o,
  output logic [63:0]      W_valM_o,
  output logic [2:0]       W_stat_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic        vld;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{vld: 1'b0, icode: INOP, stat: SAOK,
                                  dst_e: RNONE, val_e: 64'd0,
                                  dst_m: RNONE, val_m: 64'd0};

  state_t           state_q, state_nxt;
  w_reg_t           w_q, w_nxt;
  logic [2:0]       stat_q, stat_nxt;
  logic [CNT_W-1:0] retired_q, retired_nxt;
  logic [CNT_W-1:0] cycles_q, cycles_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_RUN;
      w_q       <= W_BUBBLE;
      stat_q    <= SAOK;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_nxt;
      w_q       <= w_nxt;
      stat_q    <= stat_nxt;
      retired_q <= retired_nxt;
      cycles_q  <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    w_nxt       = w_q;
    stat_nxt    = stat_q;
    retired_nxt = retired_q;
    cycles_nxt  = cycles_q;
    case (state_q)
      S_RUN: begin
        cycles_nxt = cycles_q + 1'b1;
        // An instruction retires on the edge it leaves W, so a stalled one is counted only once.
        if (w_q.vld && (w_q.stat == SAOK) && !W_stall_i)
          retired_nxt = retired_q + 1'b1;
        if (w_q.vld && (w_q.stat != SAOK)) begin
          state_nxt = S_HALT;
          stat_nxt  = w_q.stat;
        end
        if (W_bubble_i)
          w_nxt = W_BUBBLE;
        else if (!W_stall_i)
          w_nxt = '{vld: 1'b1, icode: M_icode_i, stat: m_stat_i,
                    dst_e: M_dstE_i, val_e: M_valE_i,
                    dst_m: M_dstM_i, val_m: m_valM_i};
      end
      default: ;
    endcase
  end

  logic wr_en;
  assign wr_en = (state_q == S_RUN) && (w_q.stat == SAOK);

  assign W_icode_o = w_q.icode;
  assign W_stat_o  = w_q.stat;
  assign W_dstE_o  = wr_en ? w_q.dst_e : RNONE;
  assign W_dstM_o  = wr_en ? w_q.dst_m : RNONE;
  assign W_valE_o  = w_q.val_e;
  assign W_valM_o  = w_q.val_m;
  assign stat_o    = (state_q == S_HALT) ? stat_q : SAOK;
  assign halted_o  = (state_q == S_HALT);
  assign retired_o = retired_q;
  assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_writeback.sv
// Table-driven bench for writeback: each row is one clock edge; its expected outputs go through a scoreboard queue.
module tb_writeback;

  localparam logic [2:0] SAOK = 3'd1, SADR = 3'd3;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP = 4'h1, IRRMOVQ = 4'h2, IMRMOVQ = 4'h5, IOPQ = 4'h6, IPOPQ = 4'hB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        W_stall = 1'b0, W_bubble = 1'b0;
  logic [3:0]  M_icode = INOP;
  logic [2:0]  m_stat = SAOK;
  logic [3:0]  M_dstE = RNONE, M_dstM = RNONE;
  logic [63:0] M_valE = '0, m_valM = '0;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [2:0]  W_stat, stat;
  logic        halted;
  logic [31:0] retired, cycles;

  writeback #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .W_stall_i(W_stall), .W_bubble_i(W_bubble),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .W_icode_o(W_icode), .W_dstE_o(W_dstE), .W_valE_o(W_valE), .W_dstM_o(W_dstM),
    .W_valM_o(W_valM), .W_stat_o(W_stat), .stat_o(stat), .halted_o(halted),
    .retired_o(retired), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  wstat;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic [2:0]  stat;
    logic        halt;
    logic [31:0] ret;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        bubble;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[22];
  exp_t sb[$];

  function automatic exp_t ex(logic [3:0] ic, logic [2:0] ws, logic [3:0] de, logic [63:0] ve,
                              logic [3:0] dm, logic [63:0] vm, logic [2:0] st, logic h,
                              logic [31:0] ret, logic [31:0] cyc);
    exp_t r;
    r.icode = ic; r.wstat = ws; r.de = de; r.ve = ve; r.dm = dm; r.vm = vm;
    r.stat = st; r.halt = h; r.ret = ret; r.cyc = cyc;
    return r;
  endfunction

  function automatic vec_t vv(logic r, logic st, logic bu, logic [3:0] ic, logic [2:0] s,
                              logic [3:0] de, logic [63:0] ve, logic [3:0] dm, logic [63:0] vm,
                              exp_t e);
    vec_t x;
    x.rst_n = r; x.stall = st; x.bubble = bu; x.icode = ic; x.stat = s;
    x.de = de; x.ve = ve; x.dm = dm; x.vm = vm; x.e = e;
    return x;
  endfunction

  // Filler stimulus for rows where the M-stage inputs must have no effect.
  function automatic vec_t vx(logic r, logic st, logic bu, exp_t e);
    return vv(r, st, bu, IOPQ, SAOK, 4'h7, 64'hDEAD, RNONE, 64'h0, e);
  endfunction

  task automatic chk(string nm, int row, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h want %0h", nm, row, act, exp);
    end
  endtask

  initial begin
    exp_t rst_e, halt_e, e;
    rst_e  = ex(INOP, SAOK, RNONE, 64'h0, RNONE, 64'h0, SAOK, 1'b0, 0, 0);
    halt_e = ex(IRRMOVQ, SADR, RNONE, 64'h77, RNONE, 64'h0, SADR, 1'b1, 2, 14);

    tbl[0] = vx(1'b0, 1'b0, 1'b0, rst_e);
    for (int i = 1; i <= 5; i++)
      tbl[i] = vx(1'b1, 1'b0, 1'b1, ex(INOP, SAOK, RNONE, 0, RNONE, 0, SAOK, 1'b0, 0, i));
    tbl[6]  = vv(1'b1, 1'b0, 1'b0, IOPQ, SAOK, 4'h3, 64'h2A, RNONE, 64'h0,
                 ex(IOPQ, SAOK, 4'h3, 64'h2A, RNONE, 64'h0, SAOK, 1'b0, 0, 6));
    tbl[7]  = vv(1'b1, 1'b0, 1'b0, IMRMOVQ, SAOK, RNONE, 64'h100, 4'h5, 64'h1234,
                 ex(IMRMOVQ, SAOK, RNONE, 64'h100, 4'h5, 64'h1234, SAOK, 1'b0, 1, 7));
    for (int i = 8; i <= 10; i++)
      tbl[i] = vv(1'b1, 1'b1, 1'b0, IOPQ, SAOK, 4'h9, 64'h55, RNONE, 64'h0,
                  ex(IMRMOVQ, SAOK, RNONE, 64'h100, 4'h5, 64'h1234, SAOK, 1'b0, 1, i));
    tbl[11] = vv(1'b1, 1'b0, 1'b0, IOPQ, SAOK, 4'h9, 64'h55, RNONE, 64'h0,
                 ex(IOPQ, SAOK, 4'h9, 64'h55, RNONE, 64'h0, SAOK, 1'b0, 2, 11));
    tbl[12] = vx(1'b1, 1'b1, 1'b1, ex(INOP, SAOK, RNONE, 0, RNONE, 0, SAOK, 1'b0, 2, 12));
    tbl[13] = vv(1'b1, 1'b0, 1'b0, IRRMOVQ, SADR, 4'h4, 64'h77, RNONE, 64'h0,
                 ex(IRRMOVQ, SADR, RNONE, 64'h77, RNONE, 64'h0, SAOK, 1'b0, 2, 13));
    tbl[14] = vv(1'b1, 1'b1, 1'b0, IOPQ, SAOK, 4'h1, 64'h99, RNONE, 64'h0, halt_e);
    tbl[15] = vx(1'b1, 1'b0, 1'b0, halt_e);
    tbl[16] = vx(1'b1, 1'b0, 1'b1, halt_e);
    tbl[17] = vv(1'b1, 1'b0, 1'b0, IOPQ, SAOK, 4'h1, 64'h99, RNONE, 64'h0, halt_e);
    tbl[18] = vx(1'b0, 1'b1, 1'b1, rst_e);
    tbl[19] = vv(1'b1, 1'b0, 1'b0, IOPQ, SAOK, 4'h2, 64'hABC, RNONE, 64'h0,
                 ex(IOPQ, SAOK, 4'h2, 64'hABC, RNONE, 64'h0, SAOK, 1'b0, 0, 1));
    tbl[20] = vv(1'b1, 1'b0, 1'b0, IPOPQ, SAOK, 4'h6, 64'h11, 4'h6, 64'h22,
                 ex(IPOPQ, SAOK, 4'h6, 64'h11, 4'h6, 64'h22, SAOK, 1'b0, 1, 2));
    tbl[21] = vx(1'b1, 1'b0, 1'b1, ex(INOP, SAOK, RNONE, 0, RNONE, 0, SAOK, 1'b0, 2, 3));

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; W_stall = tbl[i].stall; W_bubble = tbl[i].bubble;
      M_icode = tbl[i].icode; m_stat = tbl[i].stat;
      M_dstE = tbl[i].de; M_valE = tbl[i].ve; M_dstM = tbl[i].dm; m_valM = tbl[i].vm;
      sb.push_back(tbl[i].e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty row %0d", i);
      end else begin
        e = sb.pop_front();
        chk("W_icode", i, 64'(W_icode), 64'(e.icode));
        chk("W_stat",  i, 64'(W_stat),  64'(e.wstat));
        chk("W_dstE",  i, 64'(W_dstE),  64'(e.de));
        chk("W_valE",  i, W_valE,       e.ve);
        chk("W_dstM",  i, 64'(W_dstM),  64'(e.dm));
        chk("W_valM",  i, W_valM,       e.vm);
        chk("stat",    i, 64'(stat),    64'(e.stat));
        chk("halted",  i, 64'(halted),  64'(e.halt));
        chk("retired", i, 64'(retired), 64'(e.ret));
        chk("cycles",  i, 64'(cycles),  64'(e.cyc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
